ahblite_uart_ctrl: RTL

AHB-Lite slave that sequences the SoC UART transmitter and buffers the UART receiver for the Cortex-M0. It sits on one interconnect port (HSEL_Px) and drives the UART's tx_en/UART_TX_data handshake from a TX FIFO. It captures UART_RX_data on each receive strobe and raises interrupt_UART for IRQ[0].

---
 rtl/ahblite_uart_ctrl_if.sv | 24 ++
 rtl/ahblite_uart_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahblite_uart_ctrl_if.sv
// AHB-Lite slave port bundle for ahblite_uart_ctrl.
// The interconnect side uses the master modport, the peripheral uses slave.
interface ahblite_uart_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahblite_uart_ctrl.sv
// AHB-Lite UART controller: TX FIFO + start/finish sequencer, RX buffer, IRQ.
// Define UART_RX_FIFO_EN to turn the RX holding register into a TX_DEPTH FIFO.
module ahblite_uart_ctrl #(
  parameter int TX_DEPTH      = 8,
  parameter int START_TIMEOUT = 16
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahblite_uart_ctrl_if.slave  bus,
  output logic [7:0]          UART_TX_data,
  output logic                tx_en,
  input  logic                tx_busy,
  input  logic [7:0]          UART_RX_data,
  input  logic                rx_valid,
  output logic                interrupt_UART
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int TW = $clog2(START_TIMEOUT) + 1;
  localparam logic [AW:0]   FIFO_FULL = TX_DEPTH[AW:0];
  localparam logic [TW-1:0] TO_LAST   = TW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_DONE} tx_state_e;
  typedef enum logic [1:0] {REG_DATA, REG_STATUS, REG_CTRL, REG_RSVD} reg_addr_e;

  // ---------------- AHB address/data phase ----------------
  logic      dp_valid, dp_write;
  reg_addr_e dp_addr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= REG_DATA;
    end else if (bus.HREADY) begin
      dp_valid <= bus.HSEL & bus.HTRANS[1];
      dp_write <= bus.HWRITE;
      dp_addr  <= reg_addr_e'(bus.HADDR[3:2]);
    end
  end

  logic wr_data, wr_status, wr_ctrl, rd_data;
  assign wr_data   = dp_valid &  dp_write & (dp_addr == REG_DATA);
  assign wr_status = dp_valid &  dp_write & (dp_addr == REG_STATUS);
  assign wr_ctrl   = dp_valid &  dp_write & (dp_addr == REG_CTRL);
  assign rd_data   = dp_valid & ~dp_write & (dp_addr == REG_DATA);

  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [TX_DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [AW:0]   tx_count;
  logic          tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == FIFO_FULL);
  assign tx_push  = wr_data & (~tx_full | tx_pop);

  // NOTE: storage arrays carry no reset; the pointers and count define what is valid.
  always_ff @(posedge HCLK) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.HWDATA[7:0];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // ---------------- TX sequencer ----------------
  tx_state_e     state, state_nxt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    tx_data_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      to_cnt    <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state     <= state_nxt;
      to_cnt    <= (state == WAIT_START && state_nxt == WAIT_START) ? to_cnt + 1'b1 : '0;
      if (tx_pop) tx_data_q <= tx_mem[tx_rd_ptr];
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    tx_en     = 1'b0;
    tx_pop    = 1'b0;
    case (state)
      IDLE:       if (!tx_empty && !tx_busy) state_nxt = LOAD;
      LOAD: begin
        tx_en     = 1'b1;
        tx_pop    = 1'b1;
        state_nxt = WAIT_START;
      end
      WAIT_START: begin
        if (tx_busy)               state_nxt = WAIT_DONE;
        else if (to_cnt == TO_LAST) state_nxt = IDLE;
      end
      WAIT_DONE:  if (!tx_busy) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // The head byte is visible during LOAD itself, then held until the next LOAD.
  assign UART_TX_data = tx_en ? tx_mem[tx_rd_ptr] : tx_data_q;

  logic tx_busy_st;
  assign tx_busy_st = (state != IDLE) | tx_busy;

  // ---------------- RX path ----------------
  logic       rx_valid_st, rx_pop, rx_ovr_set;
  logic [7:0] rx_byte;

  assign rx_pop = rd_data & rx_valid_st;

`ifdef UART_RX_FIFO_EN
  logic [7:0]    rx_mem [TX_DEPTH];
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [AW:0]   rx_count;
  logic          rx_full, rx_push;

  assign rx_valid_st = (rx_count != '0);
  assign rx_full     = (rx_count == FIFO_FULL);
  assign rx_push     = rx_valid & (~rx_full | rx_pop);
  assign rx_ovr_set  = rx_valid & rx_full & ~rx_pop;
  assign rx_byte     = rx_mem[rx_rd_ptr];

  always_ff @(posedge HCLK) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= UART_RX_data;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end
`else
  assign rx_ovr_set = rx_valid & rx_valid_st & ~rx_pop;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_byte     <= 8'h00;
      rx_valid_st <= 1'b0;
    end else if (rx_valid) begin
      rx_byte     <= UART_RX_data;
      rx_valid_st <= 1'b1;
    end else if (rx_pop) begin
      rx_valid_st <= 1'b0;
    end
  end
`endif

  // ---------------- Sticky flags and CTRL ----------------
  logic tx_ovf, rx_ovr, rx_ie, txe_ie;

  // A new error event in the same cycle as a clear wins, so it is never lost.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tx_ovf <= 1'b0;
      rx_ovr <= 1'b0;
      rx_ie  <= 1'b0;
      txe_ie <= 1'b0;
    end else begin
      if (wr_data & tx_full & ~tx_pop)       tx_ovf <= 1'b1;
      else if (wr_status & bus.HWDATA[5])    tx_ovf <= 1'b0;
      if (rx_ovr_set)                        rx_ovr <= 1'b1;
      else if (wr_status & bus.HWDATA[3])    rx_ovr <= 1'b0;
      if (wr_ctrl) begin
        rx_ie  <= bus.HWDATA[0];
        txe_ie <= bus.HWDATA[1];
      end
    end
  end

  // ---------------- Read mux and interrupt ----------------
  logic [31:0] rdata;

  always_comb begin
    rdata = 32'h0;
    if (dp_valid && !dp_write) begin
      case (dp_addr)
        REG_DATA:   rdata = {24'h0, rx_byte};
        REG_STATUS: rdata = {26'h0, tx_ovf, tx_busy_st, rx_ovr, rx_valid_st, tx_empty, tx_full};
        REG_CTRL:   rdata = {30'h0, txe_ie, rx_ie};
        default:    rdata = 32'h0;
      endcase
    end
  end

  assign bus.HRDATA     = rdata;
  assign interrupt_UART = (rx_ie & rx_valid_st) | (txe_ie & tx_empty & ~tx_busy_st);

  logic unused_bits;
  assign unused_bits = ^{bus.HTRANS[0], bus.HSIZE, bus.HADDR[31:4], bus.HADDR[1:0],
                         bus.HWDATA[31:8]};

endmodule
